dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single data-memory instance (`data_mem`, byte-lane block RAM, synchronous read) between the CPU load/store unit (port 0) and a secondary master such as DMA or a video/peripheral engine (port 1). It grants one access per cycle and drives `data_mem`'s address, memop, write-data and write-enable inputs. It returns read data and a response pulse to the owner one cycle after grant. Misaligned and illegal accesses are rejected before they reach memory.

## Interface
- Parameters: none; address and data widths are fixed at 32.
- `clock` in 1 — single clock; `data_mem` `rdclk` and `wrclk` are both tied to it.
- `resetn` in 1 — asynchronous, active-low reset.
- `req` in 2 — access request per port; held with its arguments until `gnt`.
- `we` in 2 — per port, 1 = store.
- `memop` in 6 — per port 3-bit code; port n uses bits [3n+2:3n]. Codes: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `addr` in 64 — per port byte address; port n uses bits [32n+31:32n].
- `wdata` in 64 — per port store data, same packing as `addr`.
- `gnt` out 2 — one-hot pulse; the request is accepted this cycle.
- `rvalid` out 2 — one-hot response pulse, one cycle after `gnt`, for loads and for rejected accesses.
- `err` out 1 — qualifies `rvalid`; 1 = access was rejected.
- `rdata` out 32 — load data, shared by both ports; valid only with `rvalid`.
- `mem_addr` out 32, `mem_datain` out 32, `mem_memop` out 3, `mem_we` out 1 — to `data_mem`.
- `mem_dataout` in 32 — from `data_mem`.

## Operation
- States:
  - IDLE: no response owed.
  - RESP: response owed to `owner_q`.
- Arbitration, each cycle, in either state:
  - Select one requesting port.
  - Assert `gnt` for that port, combinationally in the same cycle.
  - Mux its `addr`, `memop` and `wdata` onto the `mem_*` outputs.
- A grant is legal only when the access is legal:
  - Illegal memop: 011, 110, 111.
  - Misaligned halfword: halfword op with `addr[0]`=1.
  - Misaligned word: word op with `addr[1:0]`≠00.
- Legal store: `mem_we`=1 in the grant cycle. Stores produce no `rvalid`.
- Legal load: `mem_we`=0. Next state is RESP with `owner_q`=port and `err_q`=0.
- Illegal access, load or store: `mem_we` is forced to 0. Next state is RESP with `err_q`=1; `rdata` is don't-care.
- RESP: `rvalid[owner_q]`=1, `err`=`err_q`, `rdata`=`mem_dataout`. The next state depends on the grant made in the same cycle: RESP if it was a load or an illegal access, otherwise IDLE.
- No request: `mem_we`=0, `gnt`=0, next state IDLE.
- Requester changing arguments while `req`=1 and `gnt`=0: not supported (protocol violation).

## Timing
- Reset, asynchronous: state IDLE, `owner_q`=0, `err_q`=0, RR pointer=0. Outputs `gnt`, `rvalid`, `err`, `mem_we` are 0; `mem_addr`, `mem_datain`, `mem_memop` are 0.
- Grant latency is 0 cycles: `gnt` is asserted in the cycle `req` is seen, if the port wins.
- Load latency: `rvalid` at G+1. Stores are complete at the G clock edge.
- Throughput: one access per cycle. Back-to-back loads give consecutive `rvalid`.
- Both ports requesting: exactly one `gnt`; the loser holds `req` and is served next per the policy.
- Reset asserted during RESP: the pending `rvalid` is dropped and is not replayed after reset.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - 1-bit pointer names the preferred port.
  - After any grant, the pointer moves to the other port.
  - Under contention, grants alternate 0,1,0,1.
- `DMEM_ARB_RR_EN` undefined: fixed priority, port 0 always wins. No pointer flop exists.

## Structure
- Shared package `dmem_pkg` holds:
  - memop code constants: `MEMOP_B`, `MEMOP_H`, `MEMOP_W`, `MEMOP_BU`, `MEMOP_HU`.
  - the state enum `{ARB_IDLE, ARB_RESP}`.
  - function `memop_legal(memop, addr[1:0])`.
- Sub-module `dmem_arb_pick`: combinational winner selection from `req` and pointer, with the `DMEM_ARB_RR_EN` variants. The FSM, response registers and muxing stay in `dmem_arbiter`.

## Test plan
- Port 0 `sw` 0x12345678 to 0x100, then `lw` 0x100 → `gnt[0]` both cycles; `rvalid[0]` and `rdata`=0x12345678 one cycle after the load grant.
- Port 1 `sb` 0xAB to 0x203, then `lbu` 0x203 → `rdata`=0x000000AB; `lb` → 0xFFFFFFAB.
- Both ports assert `lw` continuously for 4 cycles:
  - RR build: `gnt` sequence 01,10,01,10; `rvalid` follows one cycle later.
  - Fixed-priority build: `gnt` is 01 for all 4 cycles.
- Port 0 `lh` at 0x101, then port 1 `sw` at 0x102 → no memory write (`mem_we`=0); `rvalid`=01 with `err`=1, then `rvalid`=10 with `err`=1.
- Port 0 `memop`=111 → `err`=1 response; memory contents unchanged.
- `resetn` dropped in RESP after `lw` grant → `rvalid`=0 immediately; after release, state IDLE and no stale `rvalid`.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: memop codes, the
// arbiter state encoding and the access-legality check.
package dmem_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } arb_state_e;

  // An access is legal when its memop is a known code and the address is
  // naturally aligned for the access size.
  function automatic logic memop_legal(input logic [2:0] memop, input logic [1:0] addr_lo);
    logic ok;
    case (memop)
      MEMOP_B, MEMOP_BU: ok = 1'b1;
      MEMOP_H, MEMOP_HU: ok = (addr_lo[0] == 1'b0);
      MEMOP_W:           ok = (addr_lo == 2'b00);
      default:           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection between the two requesters.
// DMEM_ARB_RR_EN defined: round-robin, ptr_i names the preferred port.
// DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins.
module dmem_arb_pick
  import dmem_pkg::*;
(
  input  logic [1:0] req_i,
`ifdef DMEM_ARB_RR_EN
  input  logic       ptr_i,
`endif
  output logic [1:0] pick_o
);

  // One-hot winner from the current requests
  always_comb begin
    pick_o = 2'b00;
`ifdef DMEM_ARB_RR_EN
    if (req_i == 2'b11) begin
      pick_o = ptr_i ? 2'b10 : 2'b01;
    end else begin
      pick_o = req_i;
    end
`else
    if (req_i[0]) begin
      pick_o = 2'b01;
    end else begin
      pick_o = {req_i[1], 1'b0};
    end
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single data_mem instance. Grants one
// access per cycle (combinational grant), blocks illegal accesses from
// reaching memory and returns load/error responses one cycle after grant.
// Build option: DMEM_ARB_RR_EN selects round-robin instead of fixed priority.
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [5:0]  memop,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic [2:0]  mem_memop,
  output logic        mem_we,
  input  logic [31:0] mem_dataout
);

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;
  logic        err_q, err_d;
  logic [1:0]  pick_s;
  logic        any_gnt_s;
  logic        sel_s;
  logic [2:0]  sel_memop_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic        sel_we_s;
  logic        legal_s;

`ifdef DMEM_ARB_RR_EN
  logic ptr_q, ptr_d;

  dmem_arb_pick u_pick (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .pick_o (pick_s)
  );
`else
  dmem_arb_pick u_pick (
    .req_i  (req),
    .pick_o (pick_s)
  );
`endif

  // Grant, memory-side mux, response outputs and next-state decode
  always_comb begin
    gnt         = 2'b00;
    any_gnt_s   = 1'b0;
    sel_s       = 1'b0;
    sel_memop_s = 3'b000;
    sel_addr_s  = 32'h0000_0000;
    sel_wdata_s = 32'h0000_0000;
    sel_we_s    = 1'b0;
    legal_s     = 1'b0;
    mem_addr    = 32'h0000_0000;
    mem_datain  = 32'h0000_0000;
    mem_memop   = 3'b000;
    mem_we      = 1'b0;
    rvalid      = 2'b00;
    err         = 1'b0;
    rdata       = 32'h0000_0000;
    state_d     = ARB_IDLE;
    owner_d     = owner_q;
    err_d       = 1'b0;

    // Nothing is granted while reset is held, so memory never sees a write.
    if (resetn) begin
      gnt = pick_s;
    end else begin
      gnt = 2'b00;
    end
    any_gnt_s = |gnt;
    sel_s     = gnt[1];

    if (sel_s) begin
      sel_memop_s = memop[5:3];
      sel_addr_s  = addr[63:32];
      sel_wdata_s = wdata[63:32];
      sel_we_s    = we[1];
    end else begin
      sel_memop_s = memop[2:0];
      sel_addr_s  = addr[31:0];
      sel_wdata_s = wdata[31:0];
      sel_we_s    = we[0];
    end
    legal_s = memop_legal(sel_memop_s, sel_addr_s[1:0]);

    if (any_gnt_s) begin
      mem_addr   = sel_addr_s;
      mem_datain = sel_wdata_s;
      mem_memop  = sel_memop_s;
      mem_we     = sel_we_s & legal_s;
      // Loads and rejected accesses owe a response next cycle.
      if (!sel_we_s || !legal_s) begin
        state_d = ARB_RESP;
        owner_d = sel_s;
        err_d   = ~legal_s;
      end else begin
        state_d = ARB_IDLE;
      end
    end else begin
      state_d = ARB_IDLE;
    end

    case (state_q)
      ARB_RESP: begin
        rvalid = owner_q ? 2'b10 : 2'b01;
        err    = err_q;
        rdata  = mem_dataout;
      end
      default: begin
        rvalid = 2'b00;
      end
    endcase
  end

`ifdef DMEM_ARB_RR_EN
  // Preference flips to the other port after every grant
  always_comb begin
    if (any_gnt_s) begin
      ptr_d = ~sel_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // State and response-owner registers; reset drops any pending response
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a byte-lane data_mem model and a
// transaction-level reference model of arbitration, legality and responses.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  req, we;
  logic [5:0]  memop;
  logic [63:0] addr, wdata;
  logic [1:0]  gnt, rvalid;
  logic        err;
  logic [31:0] rdata, mem_addr, mem_datain, mem_dataout;
  logic [2:0]  mem_memop;
  logic        mem_we;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dmem_arbiter dut (
    .clock(clock), .resetn(resetn), .req(req), .we(we), .memop(memop),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .err(err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_datain(mem_datain),
    .mem_memop(mem_memop), .mem_we(mem_we), .mem_dataout(mem_dataout)
  );

  // ---------------- data_mem environment (synchronous read) ----------------
  logic [7:0] env_mem [0:1023] = '{default: 8'h00};
  logic [31:0] env_raw;

  always @(posedge clock) begin
    logic [9:0] a;
    int n;
    a = mem_addr[9:0];
    n = (mem_memop[1:0] == 2'b00) ? 1 : (mem_memop[1:0] == 2'b01) ? 2 : 4;
    if (mem_we) begin
      for (int i = 0; i < n; i++) env_mem[a + 10'(i)] <= mem_datain[8*i +: 8];
    end
    env_raw = {env_mem[a + 10'd3], env_mem[a + 10'd2], env_mem[a + 10'd1], env_mem[a]};
    case (mem_memop)
      3'b000:  mem_dataout <= {{24{env_raw[7]}}, env_raw[7:0]};
      3'b001:  mem_dataout <= {{16{env_raw[15]}}, env_raw[15:0]};
      3'b100:  mem_dataout <= {24'd0, env_raw[7:0]};
      3'b101:  mem_dataout <= {16'd0, env_raw[15:0]};
      default: mem_dataout <= env_raw;
    endcase
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [0:1023] = '{default: 8'h00};
  logic [1:0]  exp_rv = 2'b00;
  logic        exp_err = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  int          rr_pref = 0;
  int          model_win;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic int op_size(input logic [2:0] op);
    return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit op_legal(input logic [2:0] op, input logic [31:0] a);
    if (op == 3'd3 || op == 3'd6 || op == 3'd7) return 1'b0;
    return (a % op_size(op)) == 0;
  endfunction

  // Check current-cycle outputs against the model, then advance one clock.
  task automatic step();
    logic [2:0]  op;
    logic [31:0] a, d, v, mask;
    logic [1:0]  eg;
    bit          lg, w;
    int          sz;
    logic [1:0]  n_rv;
    logic        n_err;
    logic [31:0] n_rd;
    #1;
    model_win = -1;
    if (req == 2'b11)   model_win = RR ? rr_pref : 0;
    else if (req[0])    model_win = 0;
    else if (req[1])    model_win = 1;
    eg = (model_win < 0) ? 2'b00 : 2'(1 << model_win);
    n_rv = 2'b00; n_err = 1'b0; n_rd = 32'h0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("rvalid", 32'(rvalid), 32'(exp_rv));
    if (exp_rv != 2'b00) chk("err", 32'(err), 32'(exp_err));
    if (exp_rv != 2'b00 && !exp_err) chk("rdata", rdata, exp_rdata);
    if (model_win >= 0) begin
      op = memop[3*model_win +: 3];
      a  = addr[32*model_win +: 32];
      d  = wdata[32*model_win +: 32];
      w  = we[model_win];
      lg = op_legal(op, a);
      sz = op_size(op);
      chk("mem_we", 32'(mem_we), 32'(w && lg));
      chk("mem_addr", mem_addr, a);
      if (w && lg) begin
        for (int i = 0; i < sz; i++) ref_mem[a[9:0] + 10'(i)] = d[8*i +: 8];
      end else begin
        n_rv = 2'(1 << model_win);
        n_err = !lg;
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
        v = {ref_mem[a[9:0] + 10'd3], ref_mem[a[9:0] + 10'd2],
             ref_mem[a[9:0] + 10'd1], ref_mem[a[9:0]]} & mask;
        if (!op[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
        n_rd = v;
      end
      rr_pref = 1 - model_win;
    end else begin
      chk("mem_we_idle", 32'(mem_we), 32'd0);
    end
    @(posedge clock);
    exp_rv = n_rv; exp_err = n_err; exp_rdata = n_rd;
    @(negedge clock);
  endtask

  task automatic set_port(input int p, input logic w, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] d);
    we[p] = w;
    memop[3*p +: 3] = op;
    addr[32*p +: 32] = a;
    wdata[32*p +: 32] = d;
  endtask

  bit          pend [2];
  logic [2:0]  legal_ops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  int          mism;

  initial begin
    resetn = 1'b0; req = 2'b11; we = 2'b11; memop = 6'd0;
    addr = 64'h0000_0204_0000_0100; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_datain", mem_datain, 32'd0);
    chk("rst_mem_memop", 32'(mem_memop), 32'd0);
    @(negedge clock); resetn = 1'b1; req = 2'b00; we = 2'b00;

    // Port 0: sw then lw at 0x100
    req = 2'b01; set_port(0, 1'b1, 3'b010, 32'h100, 32'h1234_5678); step();
    set_port(0, 1'b0, 3'b010, 32'h100, 32'h0); step();
    req = 2'b00; step();
    // Port 1: sb 0xAB at 0x203, then lbu and lb
    req = 2'b10; set_port(1, 1'b1, 3'b000, 32'h203, 32'h0000_00AB); step();
    set_port(1, 1'b0, 3'b100, 32'h203, 32'h0); step();
    chk("lbu_value", exp_rdata, 32'h0000_00AB);
    set_port(1, 1'b0, 3'b000, 32'h203, 32'h0); step();
    chk("lb_value", exp_rdata, 32'hFFFF_FFAB);
    req = 2'b00; step();
    // Contention: both ports lw for four cycles
    set_port(0, 1'b0, 3'b010, 32'h100, 32'h0);
    set_port(1, 1'b0, 3'b010, 32'h200, 32'h0);
    req = 2'b11;
    for (int i = 0; i < 4; i++) step();
    req = 2'b00; step();
    // Misaligned lh then misaligned sw
    req = 2'b01; set_port(0, 1'b0, 3'b001, 32'h101, 32'h0); step();
    req = 2'b10; set_port(1, 1'b1, 3'b010, 32'h102, 32'hDEAD_BEEF); step();
    req = 2'b00; step();
    // Illegal memop store, then read back unchanged word
    req = 2'b01; set_port(0, 1'b1, 3'b111, 32'h100, 32'hCAFE_F00D); step();
    set_port(0, 1'b0, 3'b010, 32'h100, 32'h0); step();
    chk("illegal_no_write", exp_rdata, 32'h1234_5678);
    req = 2'b00; step();
    // Reset dropped while a load response is pending
    req = 2'b01; set_port(0, 1'b0, 3'b010, 32'h100, 32'h0); step();
    resetn = 1'b0;
    #1;
    chk("rst_resp_rvalid", 32'(rvalid), 32'd0);
    chk("rst_resp_gnt", 32'(gnt), 32'd0);
    exp_rv = 2'b00; exp_err = 1'b0; rr_pref = 0;
    @(posedge clock); @(negedge clock);
    resetn = 1'b1; req = 2'b00;
    step(); step();

    // Randomized traffic with request/grant handshake
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 9) < 7) begin
          logic [2:0] op;
          logic [31:0] a;
          op = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
          a = 32'h100 + 32'($urandom_range(0, 15)) * 32'd4;
          if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
          set_port(p, 1'($urandom_range(0, 1)), op, a, $urandom);
          pend[p] = 1'b1;
        end
      end
      req = {pend[1], pend[0]};
      step();
      if (model_win >= 0) pend[model_win] = 1'b0;
    end
    req = 2'b00; step();

    mism = 0;
    for (int i = 0; i < 1024; i++) if (env_mem[i] !== ref_mem[i]) mism++;
    chk("mem_image_mismatches", 32'(mism), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
